// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: IDLE/RUN/DRAIN/DONE sequencer that holds the CPU in reset and gates CPU and host memory writes.
// Optional watchdog compiled in with `define CPU_RUN_CTRL_CYCLE_LIMIT_EN.
module cpu_run_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8192,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 32,
    parameter int MAX_CYCLES   = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       stop_flag_i,
    output logic                       cpu_reset_o,
    input  logic [DATA_WIDTH/8-1:0]    cpu_we_i,
    input  logic [31:0]                cpu_addr_i,
    output logic [DATA_WIDTH/8-1:0]    mem_we_o,
    output logic [$clog2(DEPTH)-1:0]   mem_addr_o,
    input  logic                       init_en_i,
    input  logic [DATA_WIDTH/8-1:0]    init_we_i,
    output logic                       init_en_o,
    output logic [DATA_WIDTH/8-1:0]    init_we_o,
    output logic [1:0]                 state_o,
    output logic                       done_o,
    output logic [CNT_WIDTH-1:0]       cycle_cnt_o,
    output logic                       err_o,
    output logic                       aborted_o,
    output logic                       timeout_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int SH = $clog2(NB);

    if (DATA_WIDTH % 8 != 0 || DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255 || MAX_CYCLES < 1) begin : g_bad_params
        $error("cpu_run_ctrl: illegal parameter values");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t               r_state, w_next;
    logic [7:0]           r_drain, w_drain_nx;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_cpu_reset, r_done, r_err, r_aborted;
    logic [31:0]          w_word;
    logic                 w_active, w_in_range, w_start, w_viol, w_wdog;

    assign w_word     = cpu_addr_i >> SH;
    assign w_active   = (r_state == RUN) || (r_state == DRAIN);
    assign w_in_range = w_word < 32'(DEPTH);
    assign w_start    = !w_active && start_i && !abort_i;
    assign w_viol     = w_active && (((|cpu_we_i) && !w_in_range) || (init_en_i && (|init_we_i)));

    always_comb begin
        w_next     = r_state;
        w_drain_nx = r_drain;
        case (r_state)
            IDLE, DONE: w_next = w_start ? RUN : r_state;
            RUN: begin
                if (abort_i) begin
                    w_next = DONE;
                end else if (stop_flag_i) begin
                    w_next     = DRAIN;
                    w_drain_nx = 8'(DRAIN_CYCLES - 1);
                end else if (w_wdog) begin
                    w_next = DONE;
                end
            end
            DRAIN: begin
                if (abort_i || r_drain == 8'd0) w_next = DONE;
                else w_drain_nx = r_drain - 8'd1;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_drain     <= 8'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_drain     <= w_drain_nx;
            r_cpu_reset <= !((w_next == RUN) || (w_next == DRAIN));
            r_done      <= (w_next == DONE);
            if (w_start) begin
                r_cnt     <= '0;
                r_err     <= 1'b0;
                r_aborted <= 1'b0;
            end else begin
                if (r_state == RUN && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                if (w_viol) r_err <= 1'b1;
                if (w_active && abort_i) r_aborted <= 1'b1;
            end
        end
    end

`ifdef CPU_RUN_CTRL_CYCLE_LIMIT_EN
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MAX_CYCLES - 1);
    logic r_timeout;
    assign w_wdog = (r_state == RUN) && (r_cnt == LIMIT);
    // stop and abort on the limit cycle win, so the run does not count as timed out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_timeout <= 1'b0;
        else if (w_start) r_timeout <= 1'b0;
        else if (w_wdog && !abort_i && !stop_flag_i) r_timeout <= 1'b1;
    end
    assign timeout_o = r_timeout;
`else
    assign w_wdog    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign mem_addr_o  = w_word[AW-1:0];
    assign mem_we_o    = (w_active && w_in_range) ? cpu_we_i : '0;
    assign init_en_o   = init_en_i;
    assign init_we_o   = w_active ? '0 : init_we_i;
    assign state_o     = r_state;
    assign done_o      = r_done;
    assign cpu_reset_o = r_cpu_reset;
    assign cycle_cnt_o = r_cnt;
    assign err_o       = r_err;
    assign aborted_o   = r_aborted;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed stimulus with a behavioural run model checked every cycle, plus literal pins.
module tb_cpu_run_ctrl;
    localparam int  DRAIN = 4;
    localparam int  MAXC  = 100;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0, abort_i = 1'b0, stop_flag_i = 1'b0;
    logic [3:0]  cpu_we_i = '0, init_we_i = '0;
    logic [31:0] cpu_addr_i = '0;
    logic        init_en_i = 1'b0;
    logic        cpu_reset_o, init_en_o, done_o, err_o, aborted_o, timeout_o;
    logic [3:0]  mem_we_o, init_we_o;
    logic [12:0] mem_addr_o;
    logic [1:0]  state_o;
    logic [31:0] cycle_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_run_ctrl #(.DATA_WIDTH(32), .DEPTH(8192), .DRAIN_CYCLES(DRAIN), .CNT_WIDTH(32), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i), .stop_flag_i(stop_flag_i),
        .cpu_reset_o(cpu_reset_o), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .init_en_i(init_en_i), .init_we_i(init_we_i), .init_en_o(init_en_o),
        .init_we_o(init_we_o), .state_o(state_o), .done_o(done_o), .cycle_cnt_o(cycle_cnt_o),
        .err_o(err_o), .aborted_o(aborted_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Model: phase 0 idle, 1 run, 2 drain, 3 done; m_left = drain cycles remaining including the current one
    int     m_st = 0;
    int     m_left = 0;
    longint m_cnt = 0;
    bit     m_err = 0, m_ab = 0, m_to = 0;
`ifdef CPU_RUN_CTRL_CYCLE_LIMIT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    function automatic bit m_active();
        return m_st == 1 || m_st == 2;
    endfunction

    function automatic bit m_in_range();
        return (longint'(cpu_addr_i) / 4) < 8192;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st <= 0; m_left <= 0; m_cnt <= 0; m_err <= 0; m_ab <= 0; m_to <= 0;
        end else begin
            if (m_active() && ((cpu_we_i != 0 && !m_in_range()) || (init_en_i && init_we_i != 0))) m_err <= 1;
            if (m_st == 0 || m_st == 3) begin
                if (start_i && !abort_i) begin
                    m_st <= 1; m_cnt <= 0; m_err <= 0; m_ab <= 0; m_to <= 0;
                end
            end else if (m_st == 1) begin
                if (m_cnt < CMAX) m_cnt <= m_cnt + 1;
                if (abort_i) begin
                    m_st <= 3; m_ab <= 1;
                end else if (stop_flag_i) begin
                    m_st <= 2; m_left <= DRAIN;
                end else if (WD && m_cnt == MAXC - 1) begin
                    m_st <= 3; m_to <= 1;
                end
            end else begin
                if (abort_i) begin
                    m_st <= 3; m_ab <= 1;
                end else if (m_left == 1) m_st <= 3;
                else m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_state", state_o, m_st);
        chk("m_done", done_o, m_st == 3);
        chk("m_cpu_reset", cpu_reset_o, !m_active());
        chk("m_cnt", cycle_cnt_o, m_cnt);
        chk("m_err", err_o, m_err);
        chk("m_aborted", aborted_o, m_ab);
        chk("m_timeout", timeout_o, m_to);
        chk("m_mem_addr", mem_addr_o, (longint'(cpu_addr_i) / 4) % 8192);
        chk("m_mem_we", mem_we_o, (m_active() && m_in_range()) ? cpu_we_i : 0);
        chk("m_init_en", init_en_o, init_en_i);
        chk("m_init_we", init_we_o, m_active() ? 0 : init_we_i);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] addrs [5] = '{32'h0, 32'h4, 32'h13, 32'h1234, 32'hFFFF_FFFC};
    logic [3:0]  wes   [5] = '{4'h1, 4'h3, 4'hC, 4'hF, 4'h8};

    initial begin
        step;
        chk("rst_state", state_o, 0);
        chk("rst_cpu_reset", cpu_reset_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", cycle_cnt_o, 0);
        step;
        reset = 1'b1;
        abort_i = 1'b1; step; abort_i = 1'b0;
        chk("idle_abort_ignored", state_o, 0);
        init_en_i = 1'b1; init_we_i = 4'h5; #1;
        chk("idle_init_we", init_we_o, 4'h5);
        chk("idle_init_en", init_en_o, 1);
        init_en_i = 1'b0; init_we_i = 4'h0;
        // stop sequence: stop on RUN cycle 10
        start_i = 1'b1; step; start_i = 1'b0;
        chk("run1_state", state_o, 1);
        chk("run1_cpu_reset", cpu_reset_o, 0);
        chk("run1_cnt", cycle_cnt_o, 0);
        repeat (9) step;
        chk("run10_state", state_o, 1);
        chk("run10_cnt", cycle_cnt_o, 9);
        stop_flag_i = 1'b1; step; stop_flag_i = 1'b0;
        chk("drain1_state", state_o, 2);
        chk("drain1_cpu_reset", cpu_reset_o, 0);
        chk("drain1_cnt", cycle_cnt_o, 10);
        repeat (3) step;
        chk("drain4_state", state_o, 2);
        step;
        chk("done_state", state_o, 3);
        chk("done_flag", done_o, 1);
        chk("done_cpu_reset", cpu_reset_o, 1);
        chk("done_cnt", cycle_cnt_o, 10);
        step;
        chk("done_cnt_hold", cycle_cnt_o, 10);
        // init gating in RUN
        start_i = 1'b1; step; start_i = 1'b0;
        chk("restart_state", state_o, 1);
        init_en_i = 1'b1; init_we_i = 4'hF; #1;
        chk("run_init_we", init_we_o, 0);
        chk("run_init_en", init_en_o, 1);
        step;
        chk("run_init_err", err_o, 1);
        init_en_i = 1'b0; init_we_i = 4'h0;
        abort_i = 1'b1; step; abort_i = 1'b0;
        chk("abort_state", state_o, 3);
        chk("abort_flag", aborted_o, 1);
        chk("err_sticky", err_o, 1);
        // CPU address range
        start_i = 1'b1; step; start_i = 1'b0;
        chk("start_clr_err", err_o, 0);
        chk("start_clr_aborted", aborted_o, 0);
        cpu_we_i = 4'hF; cpu_addr_i = 32'h0000_8000; #1;
        chk("oor_mem_we", mem_we_o, 0);
        step;
        chk("oor_err", err_o, 1);
        cpu_addr_i = 32'h0000_7FFC; #1;
        chk("top_mem_we", mem_we_o, 4'hF);
        chk("top_mem_addr", mem_addr_o, 13'h1FFF);
        for (int i = 0; i < 5; i++) begin
            cpu_addr_i = addrs[i]; cpu_we_i = wes[i];
            step;
        end
        cpu_we_i = 4'h0; cpu_addr_i = 32'h0;
        // abort beats stop
        abort_i = 1'b1; stop_flag_i = 1'b1; step; abort_i = 1'b0; stop_flag_i = 1'b0;
        chk("prio_state", state_o, 3);
        chk("prio_aborted", aborted_o, 1);
        step;
        chk("prio_no_drain", state_o, 3);
        // async reset during DRAIN
        start_i = 1'b1; step; start_i = 1'b0;
        repeat (3) step;
        stop_flag_i = 1'b1; step; stop_flag_i = 1'b0;
        chk("pre_reset_drain", state_o, 2);
        step;
        #2 reset = 1'b0; #1;
        chk("async_rst_state", state_o, 0);
        chk("async_rst_cpu_reset", cpu_reset_o, 1);
        chk("async_rst_cnt", cycle_cnt_o, 0);
        step;
        reset = 1'b1;
        start_i = 1'b1; abort_i = 1'b1; step;
        chk("idle_start_abort", state_o, 0);
        step;
        chk("idle_start_abort2", state_o, 0);
        start_i = 1'b0; abort_i = 1'b0;
        // watchdog
        start_i = 1'b1; step; start_i = 1'b0;
        repeat (99) step;
        chk("wd_pre_state", state_o, 1);
        chk("wd_pre_cnt", cycle_cnt_o, 99);
        step;
`ifdef CPU_RUN_CTRL_CYCLE_LIMIT_EN
        chk("wd_state", state_o, 3);
        chk("wd_timeout", timeout_o, 1);
        chk("wd_done", done_o, 1);
`else
        chk("nowd_state", state_o, 1);
        chk("nowd_timeout", timeout_o, 0);
`endif
        chk("wd_cnt", cycle_cnt_o, 100);
        abort_i = 1'b1; step; abort_i = 1'b0;
        chk("final_done", state_o, 3);
        start_i = 1'b1; step; start_i = 1'b0;
        chk("restart_clr_timeout", timeout_o, 0);
        step;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL have the parameters DATA_WIDTH, DEPTH, DRAIN_CYCLES, CNT_WIDTH and MAX_CYCLES, as follows:
- DATA_WIDTH, 32, memory word width; a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- DEPTH, 8192, memory words; AW = clog2(DEPTH).
- DRAIN_CYCLES, 4, cycles the CPU keeps running after the stop flag (range 1..255).
- CNT_WIDTH, 32, cycle counter width.
- MAX_CYCLES, 1000000, watchdog limit; used only with CYCLE_LIMIT_EN.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-low reset; assertion is asynchronous, release is synchronous to clk.
- start_i  in  1  host request to run the program.
- abort_i  in  1  host request to stop the run.
- stop_flag_i  in  1  CPU halt indication.
- cpu_reset_o  out  1  active-high reset to the CPU.
- cpu_we_i  in  NB  CPU data-port byte write enables.
- cpu_addr_i  in  32  CPU data-port byte address.
- mem_we_o  out  NB  gated byte write enables to memory port A.
- mem_addr_o  out  AW  word address to memory port A.
- init_en_i  in  1  host init-port enable.
- init_we_i  in  NB  host init-port byte write enables.
- init_en_o  out  1  init-port enable to memory port B.
- init_we_o  out  NB  gated init-port byte write enables to memory port B.
- state_o  out  2  current state: 0 = IDLE, 1 = RUN, 2 = DRAIN, 3 = DONE.
- done_o  out  1  high while the block is in DONE.
- cycle_cnt_o  out  CNT_WIDTH  number of cycles spent in RUN.
- err_o  out  1  sticky access violation.
- aborted_o  out  1  sticky flag: the run ended through abort_i.
- timeout_o  out  1  sticky flag: the run ended through the watchdog.

Function
REQ-003 The state machine SHALL have the states IDLE, RUN, DRAIN and DONE, all registered.
REQ-004 In IDLE or DONE, start_i = 1 with abort_i = 0 SHALL move the block to RUN on the next edge; the same edge SHALL clear cycle_cnt_o, err_o, aborted_o and timeout_o.
REQ-005 In IDLE, abort_i SHALL be ignored; when start_i and abort_i are both high in IDLE, the block SHALL stay in IDLE.
REQ-006 In RUN, stop_flag_i = 1 SHALL move the block to DRAIN; a DRAIN counter SHALL load DRAIN_CYCLES-1.
REQ-007 In DRAIN, the DRAIN counter SHALL decrement each cycle; when it reaches 0, the block SHALL move to DONE, so DRAIN lasts exactly DRAIN_CYCLES cycles.
REQ-008 In RUN or DRAIN, abort_i = 1 SHALL move the block to DONE on the next edge and set aborted_o; abort_i SHALL take priority over stop_flag_i.
REQ-009 cpu_reset_o SHALL be registered and SHALL be 0 only in RUN and DRAIN; it SHALL deassert on the first RUN cycle.
REQ-010 cycle_cnt_o SHALL increment once per RUN cycle, SHALL hold in every other state, and SHALL saturate at all-ones with no wrap.
REQ-011 mem_addr_o SHALL equal cpu_addr_i >> clog2(NB), truncated to AW bits, and SHALL be combinational.
REQ-012 mem_we_o SHALL equal cpu_we_i when the untruncated word address is below DEPTH and the state is RUN or DRAIN; otherwise it SHALL be 0.
REQ-013 A nonzero cpu_we_i with an out-of-range address in RUN or DRAIN SHALL set err_o on the next edge.
REQ-014 init_en_o SHALL equal init_en_i in every state, so host reads are always allowed.
REQ-015 init_we_o SHALL equal init_we_i in IDLE and DONE, and SHALL be 0 in RUN and DRAIN.
REQ-016 init_en_i = 1 with a nonzero init_we_i in RUN or DRAIN SHALL set err_o on the next edge.
REQ-017 Once set, err_o, aborted_o and timeout_o SHALL hold until the next accepted start or until reset.
REQ-018 done_o SHALL be registered and SHALL equal (state == DONE).

Reset
REQ-019 Asserting reset (low) SHALL, at any time, including mid-RUN or mid-DRAIN, immediately force the following values:
- state IDLE and DRAIN counter 0;
- cpu_reset_o = 1;
- done_o, err_o, aborted_o and timeout_o = 0;
- cycle_cnt_o = 0.
REQ-020 The combinational outputs (mem_addr_o, mem_we_o, init_en_o, init_we_o) SHALL follow the IDLE gating rules while reset is asserted.

Configuration
REQ-021 With the macro CPU_RUN_CTRL_CYCLE_LIMIT_EN defined, the watchdog SHALL be compiled in, with the following behaviour:
- In RUN, when cycle_cnt_o reaches MAX_CYCLES-1, the next edge SHALL move the block to DONE and set timeout_o.
- stop_flag_i and abort_i on that same cycle SHALL take priority over the watchdog.
REQ-022 Without CPU_RUN_CTRL_CYCLE_LIMIT_EN, timeout_o SHALL be tied to 0 and no comparator logic SHALL be synthesised.

Verification
REQ-023 Stop sequence: reset released, start_i pulse, stop_flag_i high at RUN cycle 10, DRAIN_CYCLES = 4 -> required response:
- state sequence IDLE, RUN ×10, DRAIN ×4, DONE;
- cycle_cnt_o = 10, cpu_reset_o high again in DONE.
REQ-024 Init gating in RUN: init_en_i = 1, init_we_i = 4'hF -> init_we_o = 0, init_en_o = 1, err_o = 1 on the next cycle.
REQ-025 CPU address range: DEPTH = 8192, cpu_addr_i = 32'h0000_8000, cpu_we_i = 4'hF in RUN -> mem_we_o = 0, err_o = 1; cpu_addr_i = 32'h0000_7FFC -> mem_we_o = 4'hF, mem_addr_o = 13'h1FFF.
REQ-026 Priority: abort_i and stop_flag_i both high in RUN -> DONE on the next edge, aborted_o = 1, no DRAIN state; start_i and abort_i both high in IDLE -> stays IDLE.
REQ-027 Reset mid-run: reset driven low during DRAIN -> state IDLE and cpu_reset_o = 1 immediately, before the next clk edge.
REQ-028 Watchdog: CPU_RUN_CTRL_CYCLE_LIMIT_EN defined, MAX_CYCLES = 100, no stop_flag_i -> DONE after 100 RUN cycles, timeout_o = 1, cycle_cnt_o = 100.
